rf_wport_arb: RTL and testbench
===============================

// Module: rf_wport_arb
// PURPOSE
//  Arbitrates the single register-file write port between the in-order WB stage and a
//  long-latency unit (LU: divider/multiplier return path). WB writes pass combinationally;
//  LU results land in a 1-entry holding buffer and use the port when WB is idle, or when a
//  starvation limit is hit. Sits between wb_stage/LU and regfile; also drives the debug trace.
// PARAMETERS
//  STARVE_MAX  4  max consecutive cycles a buffered LU write may lose to WB (legal 1..2^STARVE_W-1)
//  STARVE_W    3  width of the starvation counter
// PORTS
//  clk               in   1   clock
//  resetn            in   1   asynchronous, active-low reset
//  wb_valid          in   1   WB stage holds a valid instruction
//  wb_we             in   4   WB byte write enables (any bit set = port request)
//  wb_waddr          in   5   WB destination register
//  wb_wdata          in   32  WB write data
//  wb_pc             in   32  WB instruction PC (trace)
//  wb_ready          out  1   WB may retire this cycle (feeds ws_ready_go)
//  lu_valid          in   1   LU result valid
//  lu_waddr          in   5   LU destination register
//  lu_wdata          in   32  LU result
//  lu_pc             in   32  LU instruction PC (trace)
//  lu_ready          out  1   arbiter accepts LU result this cycle
//  rf_we             out  4   regfile write enables
//  rf_waddr          out  5   regfile write address
//  rf_wdata          out  32  regfile write data
//  debug_wb_pc       out  32  trace PC of granted write
//  debug_wb_rf_wen   out  4   = rf_we
//  debug_wb_rf_wnum  out  5   = rf_waddr
//  debug_wb_rf_wdata out  32  = rf_wdata
// BEHAVIOUR
//  - State: buf_v, buf_addr[4:0], buf_data[31:0], buf_pc[31:0], starve_cnt[STARVE_W-1:0].
//  - Reset (resetn low, async): buf_v=0, starve_cnt=0; any buffered LU result discarded.
//    Outputs while in reset: rf_we=0, wb_ready=1, lu_ready=1, all data/addr/pc outputs 0.
//  - wb_req = wb_valid & |wb_we. WB with wb_we==0 needs no port: wb_ready=1.
//  - Grant (combinational, one winner per cycle):
//      gnt_lu = buf_v & (!wb_req | starve_cnt==STARVE_MAX);  gnt_wb = wb_req & !gnt_lu.
//  - wb_ready = !wb_req | gnt_wb. WB latency 0: write reaches RF in the same cycle.
//  - rf_* and debug_* select buffer when gnt_lu, WB inputs when gnt_wb, else rf_we=0 and
//    rf_waddr/rf_wdata/debug_wb_pc=0.
//  - lu_ready = !buf_v | gnt_lu (full buffer draining this cycle accepts a new result: no bubble).
//  - Capture on lu_valid & lu_ready: buf_v<=1, fields<=lu_*; else if gnt_lu: buf_v<=0.
//  - LU write to r0 (lu_waddr==0): accepted (handshake completes), not stored, never on port;
//    buf_v follows the drain rule only.
//  - LU latency: accepted result appears on RF port at earliest the next cycle.
//  - starve_cnt: <=0 when !buf_v or gnt_lu; else if wb_req wins, +1 saturating at STARVE_MAX.
//  - Same-register ordering between WB and LU is guaranteed upstream (issue scoreboard);
//    this block does not compare addresses.
// CONFIGURATION
//  RF_ARB_STAT_EN defined: adds output stat_wb_stall_cnt[31:0], +1 every cycle with
//    wb_req & !wb_ready, wraps 0xFFFFFFFF->0, cleared by reset.
//  RF_ARB_STAT_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1 Assert resetn=0 mid-cycle with buf_v=1 -> rf_we=0, lu_ready=1, wb_ready=1 immediately; entry never written.
//  2 WB only: wb_valid=1, wb_we=4'hF, addr=5, data=0x00001234 -> same cycle rf_we=F, waddr=5, wb_ready=1.
//  3 LU only: lu_valid pulse addr=7 data=0xBEEF at cycle n -> cycle n+1 rf_we=F, waddr=7, debug_wb_pc=lu_pc.
//  4 STARVE_MAX=4, buffer full, WB requesting every cycle -> WB wins 4 cycles, cycle 5 LU wins, wb_ready=0.
//  5 LU addr=0 data=0x55 -> lu_ready=1, rf_we stays 0 for all following cycles, buf_v stays 0.
//  6 LU back-to-back valid, WB idle -> one write per cycle, lu_ready=1 continuously; STAT_EN count stays 0.

Source files
------------

// File: rtl/rf_wport_arb.sv
// Purpose: arbitrate the single regfile write port between the WB stage and a 1-entry LU holding buffer.
// Latency: WB writes reach the port in the same cycle; an accepted LU result appears at the earliest one cycle later.
// Backpressure: wb_ready drops only when the buffered LU write wins the port; lu_ready drops while the buffer is full and not draining.
// Optional build macro: RF_ARB_STAT_EN adds stat_wb_stall_cnt, a wrapping count of WB stall cycles.
module rf_wport_arb #(
  parameter int STARVE_MAX = 4,
  parameter int STARVE_W   = 3
) (
  input  logic        clk,
  input  logic        resetn,
  // WB stage side
  input  logic        wb_valid,
  input  logic [3:0]  wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_pc,
  output logic        wb_ready,
  // long-latency unit side
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  input  logic [31:0] lu_pc,
  output logic        lu_ready,
  // regfile write port
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  // debug trace
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`ifdef RF_ARB_STAT_EN
  ,
  output logic [31:0] stat_wb_stall_cnt
`endif
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

  // Holding buffer and starvation state
  logic                buf_v_q,      buf_v_d;
  logic [4:0]          buf_addr_q,   buf_addr_d;
  logic [31:0]         buf_data_q,   buf_data_d;
  logic [31:0]         buf_pc_q,     buf_pc_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic wb_req;
  logic starve_at_max;
  logic gnt_lu;
  logic gnt_wb;
  logic lu_acc;
  logic lu_store;

  // Request decode and single-winner grant; a starved buffer overrides WB
  always_comb begin
    wb_req        = wb_valid & (|wb_we);
    starve_at_max = (starve_cnt_q == STARVE_MAX_C);
    gnt_lu        = buf_v_q & (~wb_req | starve_at_max);
    gnt_wb        = wb_req & ~gnt_lu;
  end

  // Handshakes; while in reset both sides see ready so nothing upstream stalls on us
  always_comb begin
    wb_ready = ~resetn | ~wb_req | gnt_wb;
    // A full buffer that drains this cycle can take a new result without a bubble
    lu_ready = ~resetn | ~buf_v_q | gnt_lu;
    lu_acc   = lu_valid & lu_ready;
    // Writes to r0 complete the handshake but are dropped rather than occupying the port
    lu_store = lu_acc & (lu_waddr != 5'd0);
  end

  // Write-port mux; idle port and reset both present all-zero fields
  always_comb begin
    rf_we       = 4'h0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'd0;
    debug_wb_pc = 32'd0;
    if (resetn) begin
      if (gnt_lu) begin
        rf_we       = 4'hF;
        rf_waddr    = buf_addr_q;
        rf_wdata    = buf_data_q;
        debug_wb_pc = buf_pc_q;
      end else if (gnt_wb) begin
        rf_we       = wb_we;
        rf_waddr    = wb_waddr;
        rf_wdata    = wb_wdata;
        debug_wb_pc = wb_pc;
      end
    end
  end

  // Trace mirrors the write port exactly
  always_comb begin
    debug_wb_rf_wen   = rf_we;
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

  // Buffer next state: capture beats drain, so a drain-and-refill cycle keeps buf_v set
  always_comb begin
    buf_v_d    = buf_v_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    if (lu_store) begin
      buf_v_d    = 1'b1;
      buf_addr_d = lu_waddr;
      buf_data_d = lu_wdata;
      buf_pc_d   = lu_pc;
    end else if (gnt_lu) begin
      buf_v_d    = 1'b0;
    end
  end

  // Starvation counter: counts cycles the buffered entry lost to WB, saturating at the limit
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (~buf_v_q | gnt_lu) begin
      starve_cnt_d = '0;
    end else if (gnt_wb && !starve_at_max) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_v_q      <= 1'b0;
      buf_addr_q   <= 5'd0;
      buf_data_q   <= 32'd0;
      buf_pc_q     <= 32'd0;
      starve_cnt_q <= '0;
    end else begin
      buf_v_q      <= buf_v_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      buf_pc_q     <= buf_pc_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef RF_ARB_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // WB stall statistics, free-running and wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (wb_req & ~wb_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_wb_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: stimulus pushes expected port behaviour into a scoreboard queue,
// a monitor pops and compares once per cycle on the falling edge.
module tb_rf_wport_arb;
  localparam int STARVE_MAX = 4;
  localparam int STARVE_W   = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_we = 4'h0;
  logic [4:0]  wb_waddr = 5'd0;
  logic [31:0] wb_wdata = 32'd0;
  logic [31:0] wb_pc = 32'd0;
  logic        wb_ready;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_waddr = 5'd0;
  logic [31:0] lu_wdata = 32'd0;
  logic [31:0] lu_pc = 32'd0;
  logic        lu_ready;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`ifdef RF_ARB_STAT_EN
  logic [31:0] stat_wb_stall_cnt;
`endif

  rf_wport_arb #(.STARVE_MAX(STARVE_MAX), .STARVE_W(STARVE_W)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_pc(wb_pc), .wb_ready(wb_ready),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_pc(lu_pc),
    .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef RF_ARB_STAT_EN
    , .stat_wb_stall_cnt(stat_wb_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected port picture for one cycle
  typedef struct {
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        wbr;
    logic        lur;
    logic [31:0] stat;
  } exp_t;

  // A pending LU result waiting for the port
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  exp_t sbq[$];
  ent_t pend[$];
  int   lost = 0;             // cycles the oldest pending result has lost to WB
  logic [31:0] stalls = 32'd0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One normal cycle: drive inputs, predict outputs from the arbitration rules, advance model
  task automatic step(input logic wv, input logic [3:0] we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] wpc,
                      input logic lv, input logic [4:0] la,
                      input logic [31:0] ld, input logic [31:0] lpc);
    exp_t e;
    ent_t n;
    bit   wreq, have, lu_turn;
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    wb_valid = wv; wb_we = we; wb_waddr = wa; wb_wdata = wd; wb_pc = wpc;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld; lu_pc = lpc;
    wreq    = wv && (we != 4'h0);
    have    = (pend.size() != 0);
    lu_turn = have && (!wreq || lost == STARVE_MAX);
    e = '{we: 4'h0, addr: 5'd0, data: 32'd0, pc: 32'd0,
          wbr: (!wreq || !lu_turn), lur: (!have || lu_turn), stat: stalls};
    if (lu_turn) begin
      e.we = 4'hF; e.addr = pend[0].a; e.data = pend[0].d; e.pc = pend[0].pc;
    end else if (wreq) begin
      e.we = we; e.addr = wa; e.data = wd; e.pc = wpc;
    end
    sbq.push_back(e);
    if (wreq && lu_turn) stalls = stalls + 32'd1;
    if (have && !lu_turn) lost = (lost < STARVE_MAX) ? lost + 1 : STARVE_MAX;
    else lost = 0;
    if (lu_turn) void'(pend.pop_front());
    if (lv && e.lur && la != 5'd0) begin
      n.a = la; n.d = ld; n.pc = lpc;
      pend.push_back(n);
    end
  endtask

  // Reset asserted mid-cycle while inputs request the port; outputs must fall back at once
  task automatic rst_step();
    exp_t e;
    @(posedge clk);
    #1;
    wb_valid = 1'b1; wb_we = 4'hF; wb_waddr = 5'd12; wb_wdata = 32'hA5A5A5A5; wb_pc = 32'h100;
    lu_valid = 1'b1; lu_waddr = 5'd13; lu_wdata = 32'h5A5A5A5A; lu_pc = 32'h200;
    #1;
    resetn = 1'b0;
    e = '{we: 4'h0, addr: 5'd0, data: 32'd0, pc: 32'd0, wbr: 1'b1, lur: 1'b1, stat: 32'd0};
    sbq.push_back(e);
    pend.delete();
    lost   = 0;
    stalls = 32'd0;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic rand_step(input int wpct);
    logic [3:0] we;
    logic [4:0] la;
    we = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
    la = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    step(($urandom_range(0, 99) < wpct), we, 5'($urandom), $urandom, $urandom,
         ($urandom_range(0, 1) == 1), la, $urandom, $urandom);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("rf_we",      {28'd0, rf_we},            {28'd0, e.we});
        chk("rf_waddr",   {27'd0, rf_waddr},         {27'd0, e.addr});
        chk("rf_wdata",   rf_wdata,                  e.data);
        chk("debug_pc",   debug_wb_pc,               e.pc);
        chk("debug_wen",  {28'd0, debug_wb_rf_wen},  {28'd0, e.we});
        chk("debug_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, e.addr});
        chk("debug_wdat", debug_wb_rf_wdata,         e.data);
        chk("wb_ready",   {31'd0, wb_ready},         {31'd0, e.wbr});
        chk("lu_ready",   {31'd0, lu_ready},         {31'd0, e.lur});
`ifdef RF_ARB_STAT_EN
        chk("stall_cnt",  stat_wb_stall_cnt,         e.stat);
`endif
      end
    end
  end

  initial begin
    // Reset state, observed twice while held
    rst_step();
    rst_step();

    // WB only: same-cycle write
    step(1'b1, 4'hF, 5'd5, 32'h00001234, 32'h1000, 1'b0, 5'd0, 32'd0, 32'd0);
    // LU only: write lands the following cycle with the LU pc
    step(1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7, 32'h0000BEEF, 32'h2000);
    idle();
    idle();

    // Starvation: buffer fills, WB requests continuously
    step(1'b1, 4'hF, 5'd1, 32'h11, 32'h3000, 1'b1, 5'd3, 32'h33, 32'h3100);
    for (int i = 0; i < 7; i++)
      step(1'b1, 4'h3, 5'(i + 8), 32'(i), 32'h3004 + 32'(i * 4), 1'b0, 5'd0, 32'd0, 32'd0);
    idle();

    // LU to r0 is swallowed
    step(1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'h55, 32'h4000);
    idle();
    idle();
    idle();

    // LU back-to-back, WB idle: one write per cycle
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b1, 5'(i + 20), 32'hC0 + 32'(i), 32'h5000 + 32'(i));
    idle();

    // WB valid with no enables never blocks and never writes
    step(1'b1, 4'h0, 5'd9, 32'hDEAD, 32'h6000, 1'b0, 5'd0, 32'd0, 32'd0);

    // Mid-cycle reset with a buffered entry: it must never reach the port
    step(1'b1, 4'hF, 5'd2, 32'h22, 32'h7000, 1'b1, 5'd17, 32'h1717, 32'h7100);
    step(1'b1, 4'hF, 5'd2, 32'h23, 32'h7004, 1'b0, 5'd0, 32'd0, 32'd0);
    rst_step();
    idle();
    idle();

    // Randomized traffic, moderate then heavy WB load
    for (int i = 0; i < 400; i++) rand_step(50);
    for (int i = 0; i < 400; i++) rand_step(92);
    idle();
    idle();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
